aes_v1_round_seq: RTL

- Sequences one full 128-bit AES round through the shared 32-bit aes_v1 word unit.
- Issues 4 SubBytes word ops, applies ShiftRows internally, then issues 4 MixColumns word ops (skipped on the last round), and XORs in the round key.
- Sits between the block-cipher driver (key schedule / round loop) and the aes_v1 instance.
- Decrypt uses the equivalent inverse cipher. The supplied round key must already be InvMixColumns-transformed by the key schedule.

---
 rtl/aes_v1_pkg.sv | 42 ++++
 rtl/aes_v1_round_seq_if.sv | 31 +++
 rtl/aes_v1_shift_rows.sv | 12 +
 rtl/aes_v1_round_seq.sv | 81 ++++++++
 4 files changed

// File: rtl/aes_v1_pkg.sv
// Shared types, FSM encodings and ShiftRows helpers for the aes_v1 round sequencer.
// Word i = column i, byte r of a word = row r.
package aes_v1_pkg;

   typedef logic [31:0]  word_t;
   typedef logic [127:0] block_t;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SUB   = 3'd1;
   localparam logic [2:0] ST_SHIFT = 3'd2;
   localparam logic [2:0] ST_MIX   = 3'd3;
   localparam logic [2:0] ST_ARK   = 3'd4;
   localparam logic [2:0] ST_RESP  = 3'd5;

   function automatic word_t get_word(input block_t s, input logic [1:0] i);
      return s[32*i +: 32];
   endfunction

   function automatic logic [7:0] get_byte(input block_t s, input logic [1:0] c, input logic [1:0] r);
      return s[32*c + 8*r +: 8];
   endfunction

   // 2-bit casts give the mod-4 column wrap for free.
   function automatic block_t shift_rows(input block_t s);
      block_t res;
      res = '0;
      for (int unsigned c = 0; c < 4; c++)
         for (int unsigned r = 0; r < 4; r++)
            res[32*c + 8*r +: 8] = get_byte(s, 2'(c + r), 2'(r));
      return res;
   endfunction

   function automatic block_t inv_shift_rows(input block_t s);
      block_t res;
      res = '0;
      for (int unsigned c = 0; c < 4; c++)
         for (int unsigned r = 0; r < 4; r++)
            res[32*c + 8*r +: 8] = get_byte(s, 2'(c - r), 2'(r));
      return res;
   endfunction

endpackage

// File: rtl/aes_v1_round_seq_if.sv
// Request/response and aes_v1 word-unit signals of the round sequencer.
interface aes_v1_round_seq_if;
   import aes_v1_pkg::*;

   logic   req_valid;
   logic   req_ready;
   logic   req_dec;
   logic   req_last;
   block_t req_state;
   block_t req_key;
   logic   rsp_valid;
   logic   rsp_ready;
   block_t rsp_state;
   logic   aes_valid;
   logic   aes_dec;
   logic   aes_mix;
   word_t  aes_rs1;
   logic   aes_ready;
   word_t  aes_rd;

   modport slave (
      input  req_valid, req_dec, req_last, req_state, req_key, rsp_ready, aes_ready, aes_rd,
      output req_ready, rsp_valid, rsp_state, aes_valid, aes_dec, aes_mix, aes_rs1
   );

   modport master (
      output req_valid, req_dec, req_last, req_state, req_key, rsp_ready, aes_ready, aes_rd,
      input  req_ready, rsp_valid, rsp_state, aes_valid, aes_dec, aes_mix, aes_rs1
   );

endinterface

// File: rtl/aes_v1_shift_rows.sv
// Combinational ShiftRows / InvShiftRows over a full 128-bit state.
module aes_v1_shift_rows
   import aes_v1_pkg::*;
(
   input  logic   dec,
   input  block_t din,
   output block_t dout
);

   always_comb dout = dec ? inv_shift_rows(din) : shift_rows(din);

endmodule

// File: rtl/aes_v1_round_seq.sv
// Sequences one 128-bit AES round through the shared 32-bit aes_v1 word unit:
// SubBytes x4, ShiftRows, MixColumns x4 (not on the last round), AddRoundKey.
module aes_v1_round_seq
   import aes_v1_pkg::*;
#(
   parameter bit ZERO_IDLE = 1'b1
) (
   input logic               g_clk,
   input logic               g_resetn,
   aes_v1_round_seq_if.slave bus
);

   logic [2:0] state_q;
   logic [1:0] idx_q;
   block_t     st_q;
   block_t     key_q;
   logic       dec_q;
   logic       last_q;
   block_t     shifted;
   word_t      word_sel;
   logic       issuing;

   aes_v1_shift_rows u_shift_rows (
      .dec  (dec_q),
      .din  (st_q),
      .dout (shifted)
   );

   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         st_q    <= '0;
         key_q   <= '0;
         dec_q   <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: if (bus.req_valid) begin
               st_q    <= bus.req_state;
               key_q   <= bus.req_key;
               dec_q   <= bus.req_dec;
               last_q  <= bus.req_last;
               idx_q   <= '0;
               state_q <= ST_SUB;
            end
            ST_SUB, ST_MIX: if (bus.aes_ready) begin
               st_q[32*idx_q +: 32] <= bus.aes_rd;
               idx_q                <= idx_q + 2'd1;
               if (idx_q == 2'd3)
                  state_q <= (state_q == ST_SUB) ? ST_SHIFT : ST_ARK;
            end
            ST_SHIFT: begin
               st_q    <= shifted;
               idx_q   <= '0;
               state_q <= last_q ? ST_ARK : ST_MIX;
            end
            ST_ARK: begin
               st_q    <= st_q ^ key_q;
               state_q <= ST_RESP;
            end
            ST_RESP: if (bus.rsp_ready) state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Word operands come straight from the held state, so they stay stable across stalls.
   always_comb begin
      issuing       = (state_q == ST_SUB) || (state_q == ST_MIX);
      word_sel      = get_word(st_q, idx_q);
      bus.req_ready = (state_q == ST_IDLE);
      bus.rsp_valid = (state_q == ST_RESP);
      bus.rsp_state = st_q;
      bus.aes_valid = issuing;
      bus.aes_dec   = dec_q;
      bus.aes_mix   = (state_q == ST_MIX);
      bus.aes_rs1   = (issuing || !ZERO_IDLE) ? word_sel : '0;
   end

endmodule
